dram_rw_sequencer: RTL and testbench
====================================

# dram_rw_sequencer

Parametrised write/read sequencer for the DRAM test macro, the successor to the fixed 16-bit single-pass write/read controller. Run lengths, data width, address width and sense timing are configurable. Three run modes are selectable per run: write only, read only, and write-then-read with on-chip compare. The block sits between the board-level start/mode logic and the macro pins. Read words are streamed out over a valid/ready port to the UART framer.

## Interface
- `DATA_W`, 16: macro data width (`D_IN`, read bus).
- `ADDR_W`, 16: macro row-address width (`R_AD`).
- `CNT_W`, 8: word-count width; a run covers 1..2^CNT_W words.
- `WR_PULSE`, 4: cycles `WRI_EN` is held high per word, ≥1.
- `SA_DLY`, 3: cycles from `RD_EN` rise to `VSAEN` pulse, ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle run request; ignored while `busy`.
- `mode`  in  2  00 write, 01 read, 10 write-then-read; 11 is treated as 10. Sampled with `start`.
- `base_addr`  in  ADDR_W  first address; sampled with `start`.
- `num_words_m1`  in  CNT_W  words minus one; sampled with `start`.
- `seed`  in  DATA_W  pattern seed; sampled with `start`.
- `rd_data`  in  DATA_W  macro read bus.
- `R_AD`  out  ADDR_W  macro address.
- `D_IN`  out  DATA_W  macro write data.
- `WRI_EN`  out  1  write strobe.
- `RD_EN`  out  1  read enable.
- `VSAEN`  out  1  sense-amp enable pulse.
- `busy`  out  1  run in progress.
- `WT_DONE`  out  1  sticky; write pass complete.
- `RD_DONE`  out  1  sticky; read pass complete.
- `out_valid`  out  1  read word available.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  DATA_W  read word.
- `err_cnt`  out  CNT_W+1  mismatch count (see Configuration).

## Operation
- Word i of a run, for i = 0..N-1 with N = `num_words_m1`+1:
  - address = (`base_addr` + i) mod 2^ADDR_W; wraps silently past all-ones.
  - pattern = (`seed` + i) mod 2^DATA_W.
- FSM states: IDLE, W_ADDR, W_PULSE, W_GAP, R_ADDR, R_WAIT, R_SENSE, R_OUT, DONE.
- IDLE:
  - `start` latches `mode`, `base_addr`, `num_words_m1` and `seed`.
  - `start` clears `WT_DONE`, `RD_DONE` and `err_cnt`, then sets `busy`.
  - Next state is W_ADDR for modes 00/10, or R_ADDR for mode 01.
- Write pass:
  - W_ADDR (1 cycle): drive `R_AD`/`D_IN`.
  - W_PULSE (`WR_PULSE` cycles): `WRI_EN`=1.
  - W_GAP (1 cycle): `WRI_EN`=0, then i++.
  - After the last word: set `WT_DONE`. Mode 10 goes to R_ADDR with i reset to 0; otherwise go to DONE.
- Read pass:
  - R_ADDR (1 cycle): drive `R_AD`.
  - R_WAIT (`SA_DLY` cycles): `RD_EN`=1.
  - R_SENSE (1 cycle): `RD_EN`=1 and `VSAEN`=1; `rd_data` is registered at the end of this cycle.
  - R_OUT: `out_valid`=1 and `out_data` = registered word, held stable until `out_valid`&&`out_ready`. Then i++, and go to R_ADDR or, after the last word, set `RD_DONE` and go to DONE.
- DONE (1 cycle): clear `busy`, then go to IDLE.
- `R_AD` and `D_IN` hold their last value between words. Strobes are low in all states not listed above.
- A `start` pulse while `busy` is dropped, not queued.

## Timing
- Reset: all outputs are 0 and the FSM is in IDLE. Reset applies at the next edge, including mid-run, and overrides `start` in the same cycle. A run interrupted by reset does not set any done flag.
- The first macro cycle (W_ADDR or R_ADDR) is the cycle after `start`.
- Write word period: `WR_PULSE`+2 cycles.
- Read word period: `SA_DLY`+3 cycles, plus back-pressure stall. The minimum with `out_ready` tied high is `SA_DLY`+3.
- `busy` falls 1 cycle after the last done flag rises.
- N = 1 and N = 2^CNT_W are both legal. The counter must not overflow before its last-word compare.
- `out_valid` is never asserted outside R_OUT. `out_data` changes only on acceptance.

## Configuration
- `DRAM_SEQ_VERIFY_EN` defined: in mode 10 the read pass compares each sampled word to word i's pattern. `err_cnt` increments per mismatch and saturates at 2^(CNT_W+1)-1. It counts on acceptance, so one word counts once.
- Not defined: the compare logic is not built, `err_cnt` is tied to 0, and mode 10 still performs both passes.

## Test plan
- Write run: mode 00, `base_addr`=16'h0010, N=4, `seed`=16'hA5A5. Required: `D_IN` sequence A5A5, A5A6, A5A7, A5A8 at `R_AD` 0010..0013. Each `WRI_EN` pulse is 4 cycles and words are 6 cycles apart. `WT_DONE` is set, `busy` clears, `RD_DONE` stays 0.
- Address wrap: mode 00, `base_addr`=16'hFFFE, N=4. Required: `R_AD` sequence FFFE, FFFF, 0000, 0001.
- Read with back-pressure: mode 01, N=3, `rd_data` model returning address XOR 16'h5555. `out_ready` low for 5 cycles on word 1. Required: `out_data` holds stable through the stall, all 3 words are delivered in order, and `RD_DONE` is set.
- Verify (macro on): mode 10, N=8, `seed`=16'h1234, memory model corrupting address base+5. Required: `err_cnt`=1, `WT_DONE`=`RD_DONE`=1. With a clean model, `err_cnt`=0.
- Busy start and reset: pulse `start` during a write pass; required: it is ignored and the run length is unchanged. Assert `rst` while `WRI_EN`=1; required: all outputs are 0 on the next edge, no done flag is set, and a new `start` runs normally.

Source files
------------

// File: rtl/dram_rw_sequencer.sv
// dram_rw_sequencer: write/read sequencer for the DRAM test macro.
// It walks N words, addr = base_addr + i and pattern = seed + i. A run is
// write-only, read-only, or write-then-read. Read words stream out over
// a valid/ready port.
// Optional build macro DRAM_SEQ_VERIFY_EN: adds on-chip compare of the
// read pass against the pattern in write-then-read mode (err_cnt).
module dram_rw_sequencer #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int CNT_W    = 8,
    parameter int WR_PULSE = 4,
    parameter int SA_DLY   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words_m1,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] R_AD,
    output logic [DATA_W-1:0] D_IN,
    output logic              WRI_EN,
    output logic              RD_EN,
    output logic              VSAEN,
    output logic              busy,
    output logic              WT_DONE,
    output logic              RD_DONE,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W:0]    err_cnt
);

    localparam int TMR_MAX = (WR_PULSE > SA_DLY) ? WR_PULSE : SA_DLY;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [3:0] {
        IDLE, W_ADDR, W_PULSE, W_GAP, R_ADDR, R_WAIT, R_SENSE, R_OUT, DONE
    } state_t;

    state_t             state, next_state;
    logic               both_q;      // write pass followed by read pass
    logic [ADDR_W-1:0]  base_q;
    logic [CNT_W-1:0]   last_q;      // index of the final word
    logic [DATA_W-1:0]  seed_q;
    logic [CNT_W-1:0]   idx_q, idx_nxt;
    logic [TMR_W-1:0]   tmr_q, tmr_nxt;
    logic               launch, accept, set_wt, set_rd;
    logic [ADDR_W-1:0]  base_sel, addr_nxt;
    logic [DATA_W-1:0]  seed_sel, pat_nxt;
    logic [ADDR_W-1:0]  r_ad_q;
    logic [DATA_W-1:0]  d_in_q;
    logic [DATA_W-1:0]  out_data_q;
    logic               wt_q, rd_q;

    assign launch = (state == IDLE) && start;
    assign accept = (state == R_OUT) && out_ready;

    // On launch the run parameters are not registered yet, so take them
    // straight from the ports when preloading the first word.
    assign base_sel = launch ? base_addr : base_q;
    assign seed_sel = launch ? seed : seed_q;
    assign addr_nxt = base_sel + ADDR_W'(idx_nxt);
    assign pat_nxt  = seed_sel + DATA_W'(idx_nxt);

    assign R_AD     = r_ad_q;
    assign D_IN     = d_in_q;
    assign busy     = (state != IDLE);
    assign WT_DONE  = wt_q;
    assign RD_DONE  = rd_q;
    assign out_data = out_data_q;

    // Next-state, word index, phase timer and strobe decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        next_state = state;
        idx_nxt    = idx_q;
        tmr_nxt    = '0;
        set_wt     = 1'b0;
        set_rd     = 1'b0;
        WRI_EN     = 1'b0;
        RD_EN      = 1'b0;
        VSAEN      = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_nxt    = '0;
                    next_state = (mode == 2'b01) ? R_ADDR : W_ADDR;
                end
            end
            W_ADDR:  next_state = W_PULSE;
            W_PULSE: begin
                WRI_EN = 1'b1;
                if (tmr_q == TMR_W'(WR_PULSE - 1)) next_state = W_GAP;
                else                                tmr_nxt    = tmr_q + 1'b1;
            end
            W_GAP: begin
                if (idx_q == last_q) begin
                    set_wt = 1'b1;
                    if (both_q) begin
                        idx_nxt    = '0;
                        next_state = R_ADDR;
                    end else begin
                        next_state = DONE;
                    end
                end else begin
                    idx_nxt    = idx_q + 1'b1;
                    next_state = W_ADDR;
                end
            end
            R_ADDR:  next_state = R_WAIT;
            R_WAIT: begin
                RD_EN = 1'b1;
                if (tmr_q == TMR_W'(SA_DLY - 1)) next_state = R_SENSE;
                else                              tmr_nxt    = tmr_q + 1'b1;
            end
            R_SENSE: begin
                RD_EN      = 1'b1;
                VSAEN      = 1'b1;
                next_state = R_OUT;
            end
            R_OUT: begin
                out_valid = 1'b1;
                if (accept) begin
                    if (idx_q == last_q) begin
                        set_rd     = 1'b1;
                        next_state = DONE;
                    end else begin
                        idx_nxt    = idx_q + 1'b1;
                        next_state = R_ADDR;
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, run parameters, macro pin registers and sticky flags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            both_q     <= 1'b0;
            base_q     <= '0;
            last_q     <= '0;
            seed_q     <= '0;
            idx_q      <= '0;
            tmr_q      <= '0;
            r_ad_q     <= '0;
            d_in_q     <= '0;
            out_data_q <= '0;
            wt_q       <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state <= next_state;
            idx_q <= idx_nxt;
            tmr_q <= tmr_nxt;
            if (launch) begin
                both_q <= mode[1];
                base_q <= base_addr;
                last_q <= num_words_m1;
                seed_q <= seed;
                wt_q   <= 1'b0;
                rd_q   <= 1'b0;
            end
            if (set_wt) wt_q <= 1'b1;
            if (set_rd) rd_q <= 1'b1;
            // Pins change only on entry to an address phase, so they hold between words.
            if (next_state == W_ADDR || next_state == R_ADDR) r_ad_q <= addr_nxt;
            if (next_state == W_ADDR)                         d_in_q <= pat_nxt;
            if (state == R_SENSE)                             out_data_q <= rd_data;
        end
    end

`ifdef DRAM_SEQ_VERIFY_EN
    logic [CNT_W:0]    err_q;
    logic [DATA_W-1:0] pat_cur;

    assign pat_cur = seed_q + DATA_W'(idx_q);
    assign err_cnt = err_q;

    // Saturating mismatch counter, stepped once per accepted read word.
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            err_q <= '0;
        end else if (accept && both_q && (out_data_q != pat_cur) && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_dram_rw_sequencer.sv
// Self-checking bench for dram_rw_sequencer: directed runs from the test
// plan plus randomized runs, all checked against rule-based expectations
// (address = base + i, pattern = seed + i) and a behavioural macro model.
module tb_dram_rw_sequencer;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 16;
    localparam int CNT_W    = 8;
    localparam int WR_PULSE = 4;
    localparam int SA_DLY   = 3;

    logic              clk, rst, start, out_ready;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_words_m1;
    logic [DATA_W-1:0] seed, rd_data;
    logic [ADDR_W-1:0] R_AD;
    logic [DATA_W-1:0] D_IN, out_data;
    logic              WRI_EN, RD_EN, VSAEN, busy, WT_DONE, RD_DONE, out_valid;
    logic [CNT_W:0]    err_cnt;

    dram_rw_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
        .WR_PULSE(WR_PULSE), .SA_DLY(SA_DLY)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .base_addr(base_addr), .num_words_m1(num_words_m1), .seed(seed),
        .rd_data(rd_data), .R_AD(R_AD), .D_IN(D_IN), .WRI_EN(WRI_EN),
        .RD_EN(RD_EN), .VSAEN(VSAEN), .busy(busy), .WT_DONE(WT_DONE),
        .RD_DONE(RD_DONE), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- macro model ----------------
    logic [DATA_W-1:0] mac_mem [0:(1<<ADDR_W)-1];
    logic              rd_model;      // 1: read bus returns address ^ 5555
    logic              corrupt_en;
    logic [ADDR_W-1:0] corrupt_addr;

    always @(posedge clk) if (WRI_EN) mac_mem[R_AD] <= D_IN;

    initial begin
        rd_data = '0;
        forever begin
            @(negedge clk);
            if (rd_model) rd_data = R_AD ^ 16'h5555;
            else rd_data = mac_mem[R_AD] ^ ((corrupt_en && R_AD == corrupt_addr) ? 16'h0001 : 16'h0000);
        end
    end

    // ---------------- consumer back-pressure ----------------
    int policy = 0;   // 0 ready high, 1 random, 2 stall word 1 for 5 valid cycles
    int stall_n = 0;

    // ---------------- monitor ----------------
    int cyc = 0, start_cyc, flag_cyc, fall_cyc, stall_viol, strobe_viol, wlen;
    int wr_rise_q[$], wr_len_q[$], rd_rise_q[$], vsa_q[$];
    logic [15:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$], rd_data_q[$];
    logic prev_stall = 1'b0, wr_p = 1'b0, rd_p = 1'b0, wt_p = 1'b0, rdd_p = 1'b0, busy_p = 1'b0;
    logic [15:0] prev_data = '0;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (policy)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (rd_data_q.size() == 1 && stall_n < 5) begin
                        out_ready = 1'b0;
                        if (out_valid) stall_n++;
                    end else out_ready = 1'b1;
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (start && !busy && !rst) start_cyc = cyc;
            if (WRI_EN && !wr_p) begin
                wr_rise_q.push_back(cyc); wr_addr_q.push_back(R_AD); wr_data_q.push_back(D_IN); wlen = 0;
            end
            if (WRI_EN) wlen++;
            if (!WRI_EN && wr_p) wr_len_q.push_back(wlen);
            if (RD_EN && !rd_p) rd_rise_q.push_back(cyc);
            if (VSAEN) begin vsa_q.push_back(cyc); rd_addr_q.push_back(R_AD); end
            if (out_valid && out_ready) rd_data_q.push_back(out_data);
            if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if ((out_valid && (WRI_EN || RD_EN || VSAEN)) || (WRI_EN && RD_EN) || (VSAEN && !RD_EN))
                strobe_viol++;
            if ((WT_DONE && !wt_p) || (RD_DONE && !rdd_p)) flag_cyc = cyc;
            if (!busy && busy_p) fall_cyc = cyc;
            wr_p = WRI_EN; rd_p = RD_EN; wt_p = WT_DONE; rdd_p = RD_DONE; busy_p = busy;
        end
    end

    task automatic clear_mon();
        wr_rise_q.delete(); wr_len_q.delete(); rd_rise_q.delete(); vsa_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); rd_data_q.delete();
        stall_viol = 0; strobe_viol = 0; start_cyc = -100; flag_cyc = -100; fall_cyc = -100;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_r_ad"}, 32'(R_AD), 0);
        check({pfx, "_d_in"}, 32'(D_IN), 0);
        check({pfx, "_ctl"}, 32'({WRI_EN, RD_EN, VSAEN, busy, WT_DONE, RD_DONE, out_valid}), 0);
        check({pfx, "_out_data"}, 32'(out_data), 0);
        check({pfx, "_err_cnt"}, 32'(err_cnt), 0);
    endtask

    // Launch a run and wait (bounded) for busy to drop; optionally pulse a
    // conflicting start while the run is busy.
    task automatic do_run(input logic [1:0] md, input logic [15:0] base, input logic [7:0] nm1,
                          input logic [15:0] sd, input int inject);
        int t;
        clear_mon();
        mode = md; base_addr = base; num_words_m1 = nm1; seed = sd;
        rd_model = (md == 2'b01);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (busy && t < 20000) begin
            @(posedge clk); #1;
            t++;
            if (t == inject) begin
                start = 1'b1; mode = 2'b01; base_addr = ~base; num_words_m1 = 8'd9;
            end else start = 1'b0;
        end
        check("run_terminates", 32'(t < 20000), 1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Compare everything recorded for the run against the sequencing rules.
    task automatic check_run(input logic [1:0] md, input logic [15:0] base, input logic [7:0] nm1,
                             input logic [15:0] sd, input bit ready_hi);
        int n = int'(nm1) + 1;
        bit dw = (md != 2'b01);
        bit dr = (md != 2'b00);
        int nerr = 0;
        int exp_err;
        logic [15:0] a, d;
        check("wr_count", 32'(wr_addr_q.size()), dw ? n : 0);
        if (dw) begin
            for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
                a = base + 16'(i);
                d = sd + 16'(i);
                check($sformatf("wr_addr[%0d]", i), 32'(wr_addr_q[i]), 32'(a));
                check($sformatf("wr_data[%0d]", i), 32'(wr_data_q[i]), 32'(d));
                if (i < wr_len_q.size()) check($sformatf("wr_len[%0d]", i), wr_len_q[i], WR_PULSE);
                if (i > 0) check($sformatf("wr_period[%0d]", i), wr_rise_q[i] - wr_rise_q[i-1], WR_PULSE + 2);
            end
            if (wr_rise_q.size() > 0) check("first_wr_cycle", wr_rise_q[0] - start_cyc, 2);
        end else if (rd_rise_q.size() > 0) begin
            check("first_rd_cycle", rd_rise_q[0] - start_cyc, 2);
        end
        check("rd_count", 32'(rd_data_q.size()), dr ? n : 0);
        if (dr) begin
            for (int i = 0; i < n && i < rd_data_q.size(); i++) begin
                a = base + 16'(i);
                if (md == 2'b01) d = a ^ 16'h5555;
                else d = (sd + 16'(i)) ^ ((corrupt_en && a == corrupt_addr) ? 16'h0001 : 16'h0000);
                if (md[1] && d != sd + 16'(i)) nerr++;
                check($sformatf("rd_data[%0d]", i), 32'(rd_data_q[i]), 32'(d));
                if (i < rd_addr_q.size()) check($sformatf("rd_addr[%0d]", i), 32'(rd_addr_q[i]), 32'(a));
                if (i < vsa_q.size() && i < rd_rise_q.size())
                    check($sformatf("sense_dly[%0d]", i), vsa_q[i] - rd_rise_q[i], SA_DLY);
                if (ready_hi && i > 0 && i < rd_rise_q.size())
                    check($sformatf("rd_period[%0d]", i), rd_rise_q[i] - rd_rise_q[i-1], SA_DLY + 3);
            end
        end
`ifdef DRAM_SEQ_VERIFY_EN
        exp_err = (nerr > (1 << (CNT_W + 1)) - 1) ? (1 << (CNT_W + 1)) - 1 : nerr;
`else
        exp_err = 0;
`endif
        check("wt_done", 32'(WT_DONE), 32'(dw));
        check("rd_done", 32'(RD_DONE), 32'(dr));
        check("busy_idle", 32'(busy), 0);
        check("err_cnt", 32'(err_cnt), exp_err);
        check("busy_fall_lag", fall_cyc - flag_cyc, 1);
        check("stall_stable", stall_viol, 0);
        check("strobe_excl", strobe_viol, 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [1:0]  md;
        logic [15:0] b, s;
        logic [7:0]  nm;
        rst = 1'b1; start = 1'b0; mode = '0; base_addr = '0; num_words_m1 = '0; seed = '0;
        rd_model = 1'b0; corrupt_en = 1'b0; corrupt_addr = '0;
        repeat (3) begin @(posedge clk); #1; end
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Write run from the test plan.
        do_run(2'b00, 16'h0010, 8'd3, 16'hA5A5, 0);
        check_run(2'b00, 16'h0010, 8'd3, 16'hA5A5, 1'b1);

        // Address wrap past all-ones.
        do_run(2'b00, 16'hFFFE, 8'd3, 16'h0001, 0);
        check_run(2'b00, 16'hFFFE, 8'd3, 16'h0001, 1'b1);

        // Read run with ready held high: minimum word period.
        do_run(2'b01, 16'h0040, 8'd3, 16'h0000, 0);
        check_run(2'b01, 16'h0040, 8'd3, 16'h0000, 1'b1);

        // Read run with a 5-cycle stall on word 1.
        policy = 2; stall_n = 0;
        do_run(2'b01, 16'h0100, 8'd2, 16'h0000, 0);
        check_run(2'b01, 16'h0100, 8'd2, 16'h0000, 1'b0);
        check("stall_cycles", stall_n, 5);
        policy = 0;

        // Write-then-read with one corrupted word, then clean.
        corrupt_en = 1'b1; corrupt_addr = 16'h0205;
        do_run(2'b10, 16'h0200, 8'd7, 16'h1234, 0);
        check_run(2'b10, 16'h0200, 8'd7, 16'h1234, 1'b1);
        corrupt_en = 1'b0;
        do_run(2'b10, 16'h0200, 8'd7, 16'h1234, 0);
        check_run(2'b10, 16'h0200, 8'd7, 16'h1234, 1'b1);

        // Mode 11 behaves as 10; start during the run is dropped.
        do_run(2'b11, 16'h0300, 8'd3, 16'h7777, 3);
        check_run(2'b11, 16'h0300, 8'd3, 16'h7777, 1'b1);

        // Reset during a write strobe, with start high in the same cycle.
        clear_mon();
        mode = 2'b10; base_addr = 16'h8000; num_words_m1 = 8'd3; seed = 16'h0F0F; rd_model = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (!WRI_EN && t < 100) begin @(posedge clk); #1; t++; end
        check("wri_seen_before_rst", 32'(WRI_EN), 1);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_zero("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("post_rst_idle", 32'({busy, WT_DONE, RD_DONE}), 0);
        do_run(2'b00, 16'h8000, 8'd3, 16'h0F0F, 0);
        check_run(2'b00, 16'h8000, 8'd3, 16'h0F0F, 1'b1);

        // Boundary lengths: N = 1 and N = 2^CNT_W.
        do_run(2'b10, 16'h4000, 8'd0, 16'hFFFF, 0);
        check_run(2'b10, 16'h4000, 8'd0, 16'hFFFF, 1'b1);
        do_run(2'b10, 16'hFF80, 8'hFF, 16'hFFF0, 0);
        check_run(2'b10, 16'hFF80, 8'hFF, 16'hFFF0, 1'b1);

        // Randomized runs with random back-pressure and corruption.
        policy = 1;
        for (int r = 0; r < 8; r++) begin
            md = 2'($urandom_range(0, 3));
            b  = 16'($urandom);
            nm = 8'($urandom_range(0, 15));
            s  = 16'($urandom);
            corrupt_en   = 1'($urandom_range(0, 1));
            corrupt_addr = b + 16'($urandom_range(0, int'(nm)));
            do_run(md, b, nm, s, 0);
            check_run(md, b, nm, s, 1'b0);
        end
        policy = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
